// File: rtl/tx_app_tail_commit.sv
// Commit stage in front of the TX buffer pointer store: reads a flow's head/tail,
// checks free space in the circular payload buffer, advances the tail on success.
module tx_app_tail_commit #(
   parameter int FLOWID_W = 8,
   parameter int PTR_W    = 16,
   parameter int LEN_W    = 17
) (
   input  logic                clk_i,
   input  logic                rst_ni,

   input  logic                cmd_val_i,
   input  logic [FLOWID_W-1:0] cmd_flowid_i,
   input  logic [LEN_W-1:0]    cmd_len_i,
   output logic                cmd_rdy_o,

   output logic                head_rd_req_val_o,
   output logic [FLOWID_W-1:0] head_rd_req_addr_o,
   input  logic                head_rd_req_rdy_i,
   input  logic                head_rd_resp_val_i,
   input  logic [PTR_W:0]      head_rd_resp_data_i,
   output logic                head_rd_resp_rdy_o,

   output logic                tail_rd_req_val_o,
   output logic [FLOWID_W-1:0] tail_rd_req_addr_o,
   input  logic                tail_rd_req_rdy_i,
   input  logic                tail_rd_resp_val_i,
   input  logic [PTR_W:0]      tail_rd_resp_data_i,
   output logic                tail_rd_resp_rdy_o,

   output logic                tail_wr_req_val_o,
   output logic [FLOWID_W-1:0] tail_wr_req_addr_o,
   output logic [PTR_W:0]      tail_wr_req_data_o,
   input  logic                tail_wr_req_rdy_i,

   output logic                resp_val_o,
   output logic [FLOWID_W-1:0] resp_flowid_o,
   output logic                resp_ok_o,
   output logic [PTR_W:0]      resp_tail_o,
   input  logic                resp_rdy_i
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      EVAL,
      WR,
      RESP
   } state_t;

   localparam logic [PTR_W:0] BUF_BYTES = {1'b1, {PTR_W{1'b0}}};

   state_t              state_q;
   logic [FLOWID_W-1:0] flowid_q;
   logic [LEN_W-1:0]    len_q;
   logic [PTR_W:0]      head_q;
   logic [PTR_W:0]      tail_q;
   logic                cmd_rdy_q;
   logic                head_req_val_q;
   logic                tail_req_val_q;
   logic                head_sent_q;
   logic                tail_sent_q;
   logic                head_resp_rdy_q;
   logic                tail_resp_rdy_q;
   logic                head_got_q;
   logic                tail_got_q;
   logic                wr_val_q;
   logic [PTR_W:0]      wr_data_q;
   logic                resp_val_q;
   logic                resp_ok_q;
   logic [PTR_W:0]      resp_tail_q;
   logic [FLOWID_W-1:0] resp_flowid_q;

   logic [PTR_W:0]      len_ext_d;
   logic [PTR_W:0]      used_d;
   logic [PTR_W:0]      free_d;
   logic                corrupt_d;
   logic                ok_d;
   logic [PTR_W:0]      new_tail_d;

   logic                head_req_hs;
   logic                tail_req_hs;
   logic                head_resp_hs;
   logic                tail_resp_hs;
   logic                both_sent;
   logic                both_got;

   assign head_req_hs  = head_req_val_q & head_rd_req_rdy_i;
   assign tail_req_hs  = tail_req_val_q & tail_rd_req_rdy_i;
   assign head_resp_hs = head_resp_rdy_q & head_rd_resp_val_i;
   assign tail_resp_hs = tail_resp_rdy_q & tail_rd_resp_val_i;
   assign both_sent    = (head_sent_q | head_req_hs) & (tail_sent_q | tail_req_hs);
   assign both_got     = (head_got_q | head_resp_hs) & (tail_got_q | tail_resp_hs);

   // Pointers carry a wrap bit, so modular subtraction gives occupancy directly.
   always_comb begin
      len_ext_d                = '0;
      len_ext_d[LEN_W-1:0]     = len_q;
      used_d                   = tail_q - head_q;
      corrupt_d                = (used_d > BUF_BYTES);
      free_d                   = BUF_BYTES - used_d;
      ok_d                     = !corrupt_d && (len_ext_d <= free_d);
      new_tail_d               = tail_q + len_ext_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         flowid_q        <= '0;
         len_q           <= '0;
         head_q          <= '0;
         tail_q          <= '0;
         cmd_rdy_q       <= 1'b1;
         head_req_val_q  <= 1'b0;
         tail_req_val_q  <= 1'b0;
         head_sent_q     <= 1'b0;
         tail_sent_q     <= 1'b0;
         head_resp_rdy_q <= 1'b0;
         tail_resp_rdy_q <= 1'b0;
         head_got_q      <= 1'b0;
         tail_got_q      <= 1'b0;
         wr_val_q        <= 1'b0;
         wr_data_q       <= '0;
         resp_val_q      <= 1'b0;
         resp_ok_q       <= 1'b0;
         resp_tail_q     <= '0;
         resp_flowid_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_val_i) begin
                  flowid_q       <= cmd_flowid_i;
                  len_q          <= cmd_len_i;
                  cmd_rdy_q      <= 1'b0;
                  head_req_val_q <= 1'b1;
                  tail_req_val_q <= 1'b1;
                  head_sent_q    <= 1'b0;
                  tail_sent_q    <= 1'b0;
                  state_q        <= RD_REQ;
               end
            end
            RD_REQ: begin
               // Each request retires on its own handshake and is never re-issued.
               if (head_req_hs) begin
                  head_req_val_q <= 1'b0;
                  head_sent_q    <= 1'b1;
               end
               if (tail_req_hs) begin
                  tail_req_val_q <= 1'b0;
                  tail_sent_q    <= 1'b1;
               end
               if (both_sent) begin
                  head_resp_rdy_q <= 1'b1;
                  tail_resp_rdy_q <= 1'b1;
                  head_got_q      <= 1'b0;
                  tail_got_q      <= 1'b0;
                  state_q         <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (head_resp_hs) begin
                  head_q          <= head_rd_resp_data_i;
                  head_got_q      <= 1'b1;
                  head_resp_rdy_q <= 1'b0;
               end
               if (tail_resp_hs) begin
                  tail_q          <= tail_rd_resp_data_i;
                  tail_got_q      <= 1'b1;
                  tail_resp_rdy_q <= 1'b0;
               end
               if (both_got) begin
                  state_q <= EVAL;
               end
            end
            EVAL: begin
               resp_flowid_q <= flowid_q;
               resp_ok_q     <= ok_d;
               resp_tail_q   <= ok_d ? new_tail_d : tail_q;
               wr_data_q     <= new_tail_d;
               if (ok_d && (len_q != '0)) begin
                  wr_val_q <= 1'b1;
                  state_q  <= WR;
               end else begin
                  resp_val_q <= 1'b1;
                  state_q    <= RESP;
               end
            end
            WR: begin
               if (tail_wr_req_rdy_i) begin
                  wr_val_q   <= 1'b0;
                  resp_val_q <= 1'b1;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               if (resp_rdy_i) begin
                  resp_val_q <= 1'b0;
                  cmd_rdy_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_rdy_o          = cmd_rdy_q;
   assign head_rd_req_val_o  = head_req_val_q;
   assign head_rd_req_addr_o = flowid_q;
   assign head_rd_resp_rdy_o = head_resp_rdy_q;
   assign tail_rd_req_val_o  = tail_req_val_q;
   assign tail_rd_req_addr_o = flowid_q;
   assign tail_rd_resp_rdy_o = tail_resp_rdy_q;
   assign tail_wr_req_val_o  = wr_val_q;
   assign tail_wr_req_addr_o = flowid_q;
   assign tail_wr_req_data_o = wr_data_q;
   assign resp_val_o         = resp_val_q;
   assign resp_flowid_o      = resp_flowid_q;
   assign resp_ok_o          = resp_ok_q;
   assign resp_tail_o        = resp_tail_q;

   // Occupancy above the buffer size means the stored pointers are corrupt.
   ptr_sane_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == EVAL) |-> !corrupt_d);

endmodule

// File: tb/tb_tx_app_tail_commit.sv
// Bench for tx_app_tail_commit: behavioural pointer store plus an arithmetic
// free-space model; directed plan scenarios followed by randomized commits.
module tb_tx_app_tail_commit;
   localparam int MODV = 131072;
   localparam int BUFB = 65536;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_val_i;
   logic [7:0]  cmd_flowid_i;
   logic [16:0] cmd_len_i;
   logic        cmd_rdy_o;
   logic        head_rd_req_val_o, head_rd_req_rdy_i, head_rd_resp_val_i, head_rd_resp_rdy_o;
   logic [7:0]  head_rd_req_addr_o;
   logic [16:0] head_rd_resp_data_i;
   logic        tail_rd_req_val_o, tail_rd_req_rdy_i, tail_rd_resp_val_i, tail_rd_resp_rdy_o;
   logic [7:0]  tail_rd_req_addr_o;
   logic [16:0] tail_rd_resp_data_i;
   logic        tail_wr_req_val_o, tail_wr_req_rdy_i;
   logic [7:0]  tail_wr_req_addr_o;
   logic [16:0] tail_wr_req_data_o;
   logic        resp_val_o, resp_ok_o, resp_rdy_i;
   logic [7:0]  resp_flowid_o;
   logic [16:0] resp_tail_o;

   always #5 clk = ~clk;

   tx_app_tail_commit #(.FLOWID_W(8), .PTR_W(16), .LEN_W(17)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_val_i(cmd_val_i), .cmd_flowid_i(cmd_flowid_i), .cmd_len_i(cmd_len_i), .cmd_rdy_o(cmd_rdy_o),
      .head_rd_req_val_o(head_rd_req_val_o), .head_rd_req_addr_o(head_rd_req_addr_o),
      .head_rd_req_rdy_i(head_rd_req_rdy_i), .head_rd_resp_val_i(head_rd_resp_val_i),
      .head_rd_resp_data_i(head_rd_resp_data_i), .head_rd_resp_rdy_o(head_rd_resp_rdy_o),
      .tail_rd_req_val_o(tail_rd_req_val_o), .tail_rd_req_addr_o(tail_rd_req_addr_o),
      .tail_rd_req_rdy_i(tail_rd_req_rdy_i), .tail_rd_resp_val_i(tail_rd_resp_val_i),
      .tail_rd_resp_data_i(tail_rd_resp_data_i), .tail_rd_resp_rdy_o(tail_rd_resp_rdy_o),
      .tail_wr_req_val_o(tail_wr_req_val_o), .tail_wr_req_addr_o(tail_wr_req_addr_o),
      .tail_wr_req_data_o(tail_wr_req_data_o), .tail_wr_req_rdy_i(tail_wr_req_rdy_i),
      .resp_val_o(resp_val_o), .resp_flowid_o(resp_flowid_o), .resp_ok_o(resp_ok_o),
      .resp_tail_o(resp_tail_o), .resp_rdy_i(resp_rdy_i)
   );

   typedef struct {
      bit          got;
      bit          ok;
      logic [16:0] tail;
      logic [7:0]  flow;
      int          lat;
      int          nwr;
      logic [7:0]  wr_addr;
      logic [16:0] wr_data;
      int          nhreq;
      int          ntreq;
      bit          wr_unstable;
      bit          resp_unstable;
      bit          busy_rdy;
      int          cmd_edge;
   } obs_t;

   logic [16:0] head_mem [256];
   logic [16:0] tail_mem [256];
   int          n_checks = 0;
   int          n_fail = 0;
   int          edge_n = 0;
   int          wr_count = 0;
   logic [7:0]  last_wr_addr;
   logic [16:0] last_wr_data;
   bit          tk_cmd, tk_rsp, tk_hreq, tk_treq;
   bit          rs_ok;
   logic [16:0] rs_tail;
   logic [7:0]  rs_flow;

   // One clock: handshakes are decided from stable pre-edge values, store reacts after the edge.
   task automatic tick();
      bit hreq, treq, hrsp, trsp, wr;
      logic [7:0] ha, ta, wa;
      logic [16:0] wd;
      hreq = head_rd_req_val_o && head_rd_req_rdy_i;  ha = head_rd_req_addr_o;
      treq = tail_rd_req_val_o && tail_rd_req_rdy_i;  ta = tail_rd_req_addr_o;
      hrsp = head_rd_resp_val_i && head_rd_resp_rdy_o;
      trsp = tail_rd_resp_val_i && tail_rd_resp_rdy_o;
      wr   = tail_wr_req_val_o && tail_wr_req_rdy_i;  wa = tail_wr_req_addr_o; wd = tail_wr_req_data_o;
      tk_rsp = resp_val_o && resp_rdy_i;
      rs_ok = resp_ok_o; rs_tail = resp_tail_o; rs_flow = resp_flowid_o;
      tk_cmd = cmd_val_i && cmd_rdy_o;
      tk_hreq = hreq; tk_treq = treq;
      @(posedge clk);
      #1;
      edge_n++;
      if (hrsp) head_rd_resp_val_i = 1'b0;
      if (trsp) tail_rd_resp_val_i = 1'b0;
      if (hreq) begin head_rd_resp_val_i = 1'b1; head_rd_resp_data_i = head_mem[ha]; end
      if (treq) begin tail_rd_resp_val_i = 1'b1; tail_rd_resp_data_i = tail_mem[ta]; end
      if (wr) begin tail_mem[wa] = wd; wr_count++; last_wr_addr = wa; last_wr_data = wd; end
      if (tk_cmd) cmd_val_i = 1'b0;
   endtask

   // Drives one command to completion with optional per-handshake stall counts; observes only.
   task automatic do_cmd(input logic [7:0] flow, input logic [16:0] len,
                         input int hs, input int ts, input int ws, input int rs, output obs_t o);
      int hc = 0, tc = 0, wc = 0, rc = 0, wr0;
      bit accepted = 0, wseen = 0, rseen = 0;
      logic [7:0] wa0;
      logic [16:0] wd0;
      logic [25:0] rp0;
      o = '{default: 0};
      wr0 = wr_count;
      cmd_val_i = 1'b1; cmd_flowid_i = flow; cmd_len_i = len;
      for (int i = 0; i < 200 && !o.got; i++) begin
         head_rd_req_rdy_i = 1'b1;
         if (head_rd_req_val_o && hc < hs) begin head_rd_req_rdy_i = 1'b0; hc++; end
         tail_rd_req_rdy_i = 1'b1;
         if (tail_rd_req_val_o && tc < ts) begin tail_rd_req_rdy_i = 1'b0; tc++; end
         tail_wr_req_rdy_i = 1'b1;
         if (tail_wr_req_val_o) begin
            if (wc < ws) begin tail_wr_req_rdy_i = 1'b0; wc++; end
            if (!wseen) begin wseen = 1; wa0 = tail_wr_req_addr_o; wd0 = tail_wr_req_data_o; end
            else if (tail_wr_req_addr_o !== wa0 || tail_wr_req_data_o !== wd0) o.wr_unstable = 1;
         end
         resp_rdy_i = 1'b1;
         if (resp_val_o) begin
            if (rc < rs) begin resp_rdy_i = 1'b0; rc++; end
            if (!rseen) begin rseen = 1; rp0 = {resp_ok_o, resp_flowid_o, resp_tail_o}; end
            else if ({resp_ok_o, resp_flowid_o, resp_tail_o} !== rp0) o.resp_unstable = 1;
         end
         tick();
         if (tk_cmd) begin accepted = 1; o.cmd_edge = edge_n; end
         if (tk_hreq) o.nhreq++;
         if (tk_treq) o.ntreq++;
         if (tk_rsp) begin
            o.got = 1; o.ok = rs_ok; o.tail = rs_tail; o.flow = rs_flow; o.lat = edge_n - o.cmd_edge;
         end else if (accepted && cmd_rdy_o) begin
            o.busy_rdy = 1;
         end
      end
      cmd_val_i = 1'b0;
      head_rd_req_rdy_i = 1'b1; tail_rd_req_rdy_i = 1'b1; tail_wr_req_rdy_i = 1'b1; resp_rdy_i = 1'b1;
      o.nwr = wr_count - wr0; o.wr_addr = last_wr_addr; o.wr_data = last_wr_data;
      $display("cmd flow=%02h len=%05h -> got=%0b ok=%0b tail=%05h writes=%0d lat=%0d",
               flow, len, o.got, o.ok, o.tail, o.nwr, o.lat);
   endtask

   // Reference: occupancy/free space from plain modular arithmetic on the stored pointers.
   function automatic void ref_commit(input int head, input int tail, input int len,
                                      output bit ok, output int rtail, output bit wr);
      int used;
      used  = (tail - head + MODV) % MODV;
      ok    = (len <= BUFB - used);
      rtail = ok ? (tail + len) % MODV : tail;
      wr    = ok && (len != 0);
   endfunction

   task automatic test_reset();
      n_checks++; if (cmd_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy got=%0b exp=1", cmd_rdy_o); end
      n_checks++; if ({head_rd_req_val_o, tail_rd_req_val_o, tail_wr_req_val_o, resp_val_o} !== 4'b0) begin
         n_fail++; $display("FAIL reset_vals got=%04b exp=0000", {head_rd_req_val_o, tail_rd_req_val_o, tail_wr_req_val_o, resp_val_o}); end
      n_checks++; if ({resp_ok_o, resp_tail_o, resp_flowid_o} !== 26'd0) begin
         n_fail++; $display("FAIL reset_resp_payload got ok=%0b tail=%05h flow=%02h exp all 0", resp_ok_o, resp_tail_o, resp_flowid_o); end
   endtask

   task automatic test_empty();
      obs_t o;
      head_mem[3] = 17'h00100; tail_mem[3] = 17'h00100;
      do_cmd(8'd3, 17'h00200, 0, 0, 0, 0, o);
      n_checks++; if (o.got !== 1'b1 || o.ok !== 1'b1 || o.tail !== 17'h00300 || o.flow !== 8'd3) begin
         n_fail++; $display("FAIL empty_resp got=%0b ok=%0b tail=%05h flow=%02h exp 1/1/00300/03", o.got, o.ok, o.tail, o.flow); end
      n_checks++; if (o.nwr !== 1 || o.wr_addr !== 8'd3 || o.wr_data !== 17'h00300) begin
         n_fail++; $display("FAIL empty_write n=%0d addr=%02h data=%05h exp 1/03/00300", o.nwr, o.wr_addr, o.wr_data); end
      n_checks++; if (o.lat !== 5) begin n_fail++; $display("FAIL empty_latency got=%0d exp=5", o.lat); end
   endtask

   task automatic test_full();
      obs_t o;
      head_mem[7] = 17'h00000; tail_mem[7] = 17'h10000;
      do_cmd(8'd7, 17'd1, 0, 0, 0, 0, o);
      n_checks++; if (o.ok !== 1'b0 || o.tail !== 17'h10000 || o.nwr !== 0) begin
         n_fail++; $display("FAIL full_resp ok=%0b tail=%05h writes=%0d exp 0/10000/0", o.ok, o.tail, o.nwr); end
      n_checks++; if (o.lat !== 4) begin n_fail++; $display("FAIL full_latency got=%0d exp=4", o.lat); end
   endtask

   task automatic test_wrap_fit();
      obs_t o;
      head_mem[32] = 17'h00010; tail_mem[32] = 17'h10000;
      do_cmd(8'd32, 17'h10, 0, 0, 0, 0, o);
      n_checks++; if (o.ok !== 1'b1 || o.tail !== 17'h10010 || o.nwr !== 1 || o.wr_data !== 17'h10010) begin
         n_fail++; $display("FAIL exact_fit ok=%0b tail=%05h writes=%0d wdata=%05h exp 1/10010/1/10010", o.ok, o.tail, o.nwr, o.wr_data); end
      tail_mem[32] = 17'h10000;
      do_cmd(8'd32, 17'h11, 0, 0, 0, 0, o);
      n_checks++; if (o.ok !== 1'b0 || o.tail !== 17'h10000 || o.nwr !== 0) begin
         n_fail++; $display("FAIL over_by_one ok=%0b tail=%05h writes=%0d exp 0/10000/0", o.ok, o.tail, o.nwr); end
   endtask

   task automatic test_index_wrap();
      obs_t o;
      head_mem[65] = 17'h0FF00; tail_mem[65] = 17'h0FFF0;
      do_cmd(8'd65, 17'h20, 0, 0, 0, 0, o);
      n_checks++; if (o.ok !== 1'b1 || o.tail !== 17'h10010 || o.wr_data !== 17'h10010) begin
         n_fail++; $display("FAIL index_wrap ok=%0b tail=%05h wdata=%05h exp 1/10010/10010", o.ok, o.tail, o.wr_data); end
      tail_mem[65] = 17'h0FFF0;
      do_cmd(8'd65, 17'h0, 0, 0, 0, 0, o);
      n_checks++; if (o.ok !== 1'b1 || o.tail !== 17'h0FFF0 || o.nwr !== 0 || o.lat !== 4) begin
         n_fail++; $display("FAIL zero_len ok=%0b tail=%05h writes=%0d lat=%0d exp 1/0fff0/0/4", o.ok, o.tail, o.nwr, o.lat); end
   endtask

   task automatic test_backpressure();
      obs_t o;
      head_mem[5] = 17'h01000; tail_mem[5] = 17'h01800;
      do_cmd(8'd5, 17'h100, 2, 0, 0, 0, o);
      n_checks++; if (o.nhreq !== 1 || o.ntreq !== 1) begin
         n_fail++; $display("FAIL read_req_count head=%0d tail=%0d exp 1/1", o.nhreq, o.ntreq); end
      n_checks++; if (o.ok !== 1'b1 || o.tail !== 17'h01900 || o.lat !== 7) begin
         n_fail++; $display("FAIL head_stall_result ok=%0b tail=%05h lat=%0d exp 1/01900/7", o.ok, o.tail, o.lat); end
      do_cmd(8'd5, 17'h100, 0, 0, 3, 0, o);
      n_checks++; if (o.wr_unstable !== 1'b0 || o.busy_rdy !== 1'b0) begin
         n_fail++; $display("FAIL wr_stall_stable unstable=%0b cmd_rdy_busy=%0b exp 0/0", o.wr_unstable, o.busy_rdy); end
      n_checks++; if (o.nwr !== 1 || o.wr_data !== 17'h01A00 || o.lat !== 8) begin
         n_fail++; $display("FAIL wr_stall_result writes=%0d wdata=%05h lat=%0d exp 1/01a00/8", o.nwr, o.wr_data, o.lat); end
      do_cmd(8'd5, 17'h40, 0, 0, 0, 4, o);
      n_checks++; if (o.resp_unstable !== 1'b0 || o.tail !== 17'h01A40 || o.lat !== 9) begin
         n_fail++; $display("FAIL resp_stall unstable=%0b tail=%05h lat=%0d exp 0/01a40/9", o.resp_unstable, o.tail, o.lat); end
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2, o3, o4;
      head_mem[9] = 17'h0; tail_mem[9] = 17'h0;
      do_cmd(8'd9, 17'h10, 0, 0, 0, 0, o1);
      do_cmd(8'd9, 17'h0, 0, 0, 0, 0, o2);
      do_cmd(8'd9, 17'h1FFFF, 0, 0, 0, 0, o3);
      do_cmd(8'd9, 17'h10, 0, 0, 0, 0, o4);
      n_checks++; if (o2.cmd_edge - o1.cmd_edge !== 6 || o3.cmd_edge - o2.cmd_edge !== 5 || o4.cmd_edge - o3.cmd_edge !== 5) begin
         n_fail++; $display("FAIL b2b_spacing got=%0d/%0d/%0d exp 6/5/5", o2.cmd_edge - o1.cmd_edge,
                            o3.cmd_edge - o2.cmd_edge, o4.cmd_edge - o3.cmd_edge); end
      n_checks++; if (o3.ok !== 1'b0 || o3.tail !== 17'h10 || o4.tail !== 17'h20) begin
         n_fail++; $display("FAIL b2b_results ok3=%0b tail3=%05h tail4=%05h exp 0/00010/00020", o3.ok, o3.tail, o4.tail); end
   endtask

   task automatic test_reset_mid_wr();
      obs_t o;
      bit in_wr = 0;
      int wr0;
      head_mem[51] = 17'h0; tail_mem[51] = 17'h0;
      tail_wr_req_rdy_i = 1'b0;
      cmd_val_i = 1'b1; cmd_flowid_i = 8'd51; cmd_len_i = 17'h80;
      for (int i = 0; i < 20 && !in_wr; i++) begin
         tick();
         if (tail_wr_req_val_o) in_wr = 1;
      end
      tick();
      wr0 = wr_count;
      n_checks++; if (in_wr !== 1'b1) begin n_fail++; $display("FAIL reach_wr got=%0b exp=1", in_wr); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({head_rd_req_val_o, tail_rd_req_val_o, tail_wr_req_val_o, resp_val_o} !== 4'b0 || cmd_rdy_o !== 1'b1) begin
         n_fail++; $display("FAIL async_reset vals=%04b cmd_rdy=%0b exp 0000/1",
                            {head_rd_req_val_o, tail_rd_req_val_o, tail_wr_req_val_o, resp_val_o}, cmd_rdy_o); end
      head_rd_resp_val_i = 1'b0; tail_rd_resp_val_i = 1'b0; tail_wr_req_rdy_i = 1'b1; cmd_val_i = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      n_checks++; if (wr_count !== wr0 || tail_mem[51] !== 17'h0) begin
         n_fail++; $display("FAIL dropped_write writes=%0d tail=%05h exp %0d/00000", wr_count, tail_mem[51], wr0); end
      do_cmd(8'd51, 17'h80, 0, 0, 0, 0, o);
      n_checks++; if (o.ok !== 1'b1 || o.tail !== 17'h80 || o.nwr !== 1 || o.lat !== 5) begin
         n_fail++; $display("FAIL after_reset ok=%0b tail=%05h writes=%0d lat=%0d exp 1/00080/1/5", o.ok, o.tail, o.nwr, o.lat); end
   endtask

   task automatic test_random();
      obs_t o;
      int head, used, len, etail, hs, ts, ws, rs;
      bit eok, ewr;
      logic [7:0] flow;
      for (int n = 0; n < 60; n++) begin
         flow = 8'($urandom_range(0, 255));
         head = $urandom_range(0, MODV - 1);
         used = ($urandom_range(0, 3) == 0) ? BUFB : $urandom_range(0, BUFB);
         head_mem[flow] = 17'(head);
         tail_mem[flow] = 17'((head + used) % MODV);
         case ($urandom_range(0, 3))
            0: len = 0;
            1: len = BUFB - used;
            2: len = BUFB - used + 1;
            default: len = $urandom_range(0, MODV - 1);
         endcase
         if ($urandom_range(0, 1) == 0) begin hs = 0; ts = 0; ws = 0; rs = 0; end
         else begin hs = $urandom_range(0, 3); ts = $urandom_range(0, 3); ws = $urandom_range(0, 3); rs = $urandom_range(0, 3); end
         ref_commit(head, (head + used) % MODV, len, eok, etail, ewr);
         do_cmd(flow, 17'(len), hs, ts, ws, rs, o);
         n_checks++; if (o.got !== 1'b1 || o.ok !== eok || o.tail !== 17'(etail) || o.flow !== flow) begin
            n_fail++; $display("FAIL rand_resp[%0d] got=%0b ok=%0b tail=%05h flow=%02h exp 1/%0b/%05h/%02h",
                               n, o.got, o.ok, o.tail, o.flow, eok, etail, flow); end
         n_checks++; if (o.nwr !== int'(ewr) || (ewr && (o.wr_data !== 17'(etail) || o.wr_addr !== flow))) begin
            n_fail++; $display("FAIL rand_write[%0d] writes=%0d data=%05h addr=%02h exp %0d/%05h/%02h",
                               n, o.nwr, o.wr_data, o.wr_addr, ewr, etail, flow); end
         if (hs + ts + ws + rs == 0) begin
            n_checks++; if (o.lat !== (ewr ? 5 : 4)) begin
               n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, o.lat, ewr ? 5 : 4); end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_val_i = 1'b0; cmd_flowid_i = '0; cmd_len_i = '0;
      head_rd_req_rdy_i = 1'b1; tail_rd_req_rdy_i = 1'b1;
      head_rd_resp_val_i = 1'b0; tail_rd_resp_val_i = 1'b0;
      head_rd_resp_data_i = '0; tail_rd_resp_data_i = '0;
      tail_wr_req_rdy_i = 1'b1; resp_rdy_i = 1'b1;
      for (int i = 0; i < 256; i++) begin head_mem[i] = '0; tail_mem[i] = '0; end
      #23;
      test_reset();
      rst_n = 1'b1;
      test_empty();
      test_full();
      test_wrap_fit();
      test_index_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_wr();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end
endmodule
